tx_fifo_arbiter: RTL and testbench
==================================

Name: tx_fifo_arbiter

Overview:
- Shares one Aurora TX LocalLink channel among NSRC first-word-fall-through (FWFT) source FIFOs.
- Grants sources round-robin.
- Each grant is framed as one packet: header word, up to BURST data words, then a trailer word.
- Sits between the trigger-data FIFOs and the Aurora TX user interface; it is the transmit-side counterpart of the receive FIFO writer.

Parameters:
- WIDTH, 32, data word width; must be >= 24.
- NSRC, 4, number of source FIFOs; 2..8.
- SRCW, 2, width of source index; must satisfy 2^SRCW >= NSRC.
- BURST, 16, maximum data words per grant; 1..65535.

Ports:
- clk  in  1  system/user clock.
- rst  in  1  reset, synchronous, active-high.
- link_active  in  1  Aurora channel up.
- src_empty_i  in  NSRC  per-source FIFO empty flag.
- src_data_i  in  NSRC*WIDTH  FWFT head words; source k occupies bits [k*WIDTH +: WIDTH].
- src_rden_o  out  NSRC  per-source pop strobe.
- tx_d  out  WIDTH  LocalLink TX data.
- tx_src_rdy_n  out  1  TX data valid, active-low.
- tx_dst_rdy_n  in  1  Aurora accepts, active-low.
- grant_o  out  NSRC  one-hot current grant; zero in IDLE.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Transfer rule: a word transfers on a rising edge where tx_src_rdy_n=0 and tx_dst_rdy_n=0.
- Registered state: fsm state, rr pointer ptr[SRCW-1:0], selected source sel, word counter cnt[15:0]. All outputs decode combinationally from these registers and the inputs.
- Reset values: state IDLE, ptr=0, sel=0, cnt=0. Outputs are then src_rden_o=0, tx_src_rdy_n=1, tx_d=0, grant_o=0, busy_o=0.
- link_active=0 has the same effect as reset, except ptr is retained.
  - A packet in flight is abandoned without a trailer.
  - No pops occur while link_active=0.
- IDLE:
  - Search sources ptr+1, ptr+2, ..., ptr (mod NSRC) for the first with src_empty_i=0.
  - If one is found: sel<=it, cnt<=0, go to HEADER.
  - Otherwise stay in IDLE.
  - tx_src_rdy_n=1 and tx_d=0 throughout.
  - Arbitration latency: 1 cycle.
- HEADER:
  - tx_d = {8'hA5, zeros, sel in bits [SRCW-1:0]}; tx_src_rdy_n=0.
  - On transfer, go to DATA.
  - While tx_dst_rdy_n=1, hold tx_d stable.
- DATA:
  - tx_d = src_data_i[sel]; tx_src_rdy_n = src_empty_i[sel].
  - src_rden_o[sel] = ~src_empty_i[sel] & ~tx_dst_rdy_n, i.e. the pop coincides with the transfer.
  - cnt increments on each transfer.
  - Go to TRAILER when a transfer makes cnt reach BURST, or when src_empty_i[sel]=1 with cnt>=1.
  - The source running empty ends the burst immediately; the block does not wait for refill.
  - The source is guaranteed non-empty at grant, and DATA always carries at least one word.
- TRAILER:
  - tx_d = {8'h5A, zeros, cnt in bits [15:0]}; tx_src_rdy_n=0.
  - On transfer: ptr<=sel, go to IDLE.
- grant_o is one-hot on sel in HEADER, DATA and TRAILER.
- src_rden_o is only ever asserted for sel.
- Back-to-back: after TRAILER there is exactly one IDLE cycle before the next HEADER.
- Simultaneous events:
  - rst or link drop wins over any transfer in the same cycle; no pop is issued in that cycle.
  - src_empty_i rising in the same cycle as the BURST-th transfer: that word still transfers.

Test Plan:
- Source 1 holds 3 words (0x11,0x22,0x33), tx_dst_rdy_n=0 → TX stream 0xA5000001, 0x11, 0x22, 0x33, 0x5A000003. Exactly 3 pops on src_rden_o[1], then IDLE.
- All 4 sources each hold 20 words, BURST=16, from reset (ptr=0) → packet order: src1, src2, src3, src0 (16 words each, trailer count 0x10), then src1, src2, src3, src0 (4 words each, trailer count 0x04).
- Random tx_dst_rdy_n backpressure (50%) on a 10-word packet → tx_d is stable while stalled. Pops occur only on accepted cycles; total of 10 pops. Trailer reads 0x5A00000A.
- Source 2 empties after 5 words while 11 more are expected later → trailer count 5. Next packet goes to the next non-empty source, not source 2.
- link_active dropped for 1 cycle after the 3rd data word of a packet from src3 → tx_src_rdy_n=1 on the next cycle, no trailer sent, ptr unchanged. On link return, src3's remaining words start a new header packet.
- rst asserted mid-DATA → next cycle: state IDLE, ptr=0, all outputs at reset values, no pop during the rst cycle.

Source files
------------

// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter that frames FWFT source FIFO bursts as header/data/trailer
// packets onto a single Aurora TX LocalLink channel.
module tx_fifo_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned SRCW  = 2,
  parameter int unsigned BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  link_active,
  input  logic [NSRC-1:0]       src_empty_i,
  input  logic [NSRC*WIDTH-1:0] src_data_i,
  output logic [NSRC-1:0]       src_rden_o,
  output logic [WIDTH-1:0]      tx_d,
  output logic                  tx_src_rdy_n,
  input  logic                  tx_dst_rdy_n,
  output logic [NSRC-1:0]       grant_o,
  output logic                  busy_o
);

  localparam int unsigned CNTW = 16;

  typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_e;

  state_e            state_q, state_d;
  logic [SRCW-1:0]   ptr_q, ptr_d;
  logic [SRCW-1:0]   sel_q, sel_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]  src_word [NSRC];
  logic [WIDTH-1:0]  hdr_word;
  logic [WIDTH-1:0]  trl_word;
  logic [CNTW-1:0]   cnt_inc;
  logic [SRCW-1:0]   idx;
  logic [SRCW-1:0]   pick;
  logic              found;
  logic              sel_empty;
  logic              sel_xfer;

  for (genvar k = 0; k < NSRC; k++) begin : g_unpack
    assign src_word[k] = src_data_i[k*WIDTH +: WIDTH];
  end

  // First non-empty source after ptr, wrapping back to ptr itself last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NSRC; i++) begin
      idx = SRCW'((32'(ptr_q) + i) % NSRC);
      if (!found && !src_empty_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    hdr_word                  = '0;
    hdr_word[WIDTH-1 -: 8]    = 8'hA5;
    hdr_word[SRCW-1:0]        = sel_q;
    trl_word                  = '0;
    trl_word[WIDTH-1 -: 8]    = 8'h5A;
    trl_word[CNTW-1:0]        = cnt_q;
  end

  assign sel_empty = src_empty_i[sel_q];
  assign sel_xfer  = ~sel_empty & ~tx_dst_rdy_n;
  assign cnt_inc   = cnt_q + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a dropped link abandons the packet but keeps the rr pointer.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    if (!link_active) begin
      state_d = IDLE;
      sel_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (found) begin
            sel_d   = pick;
            cnt_d   = '0;
            state_d = HEADER;
          end
        end
        HEADER: begin
          if (!tx_dst_rdy_n) state_d = DATA;
        end
        DATA: begin
          if (sel_xfer) cnt_d = cnt_inc;
          if ((sel_xfer && (cnt_inc == CNTW'(BURST))) || (sel_empty && (cnt_q != '0)))
            state_d = TRAILER;
        end
        TRAILER: begin
          if (!tx_dst_rdy_n) begin
            ptr_d   = sel_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs; reset or link loss suppresses any transfer and pop this cycle.
  always_comb begin
    src_rden_o   = '0;
    tx_d         = '0;
    tx_src_rdy_n = 1'b1;
    grant_o      = '0;
    busy_o       = 1'b0;
    case (state_q)
      HEADER: begin
        tx_d         = hdr_word;
        tx_src_rdy_n = 1'b0;
        grant_o      = NSRC'(1) << sel_q;
        busy_o       = 1'b1;
      end
      DATA: begin
        tx_d              = src_word[sel_q];
        tx_src_rdy_n      = sel_empty;
        src_rden_o[sel_q] = sel_xfer;
        grant_o           = NSRC'(1) << sel_q;
        busy_o            = 1'b1;
      end
      TRAILER: begin
        tx_d         = trl_word;
        tx_src_rdy_n = 1'b0;
        grant_o      = NSRC'(1) << sel_q;
        busy_o       = 1'b1;
      end
      default: ;
    endcase
    if (rst || !link_active) begin
      src_rden_o   = '0;
      tx_src_rdy_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter: per-cycle vector table plus scripted
// multi-packet sequences against a queue model of the source FIFOs.
module tb_tx_fifo_arbiter;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 4;

  logic                  clk;
  logic                  rst;
  logic                  link_active;
  logic [NSRC-1:0]       src_empty_i;
  logic [NSRC*WIDTH-1:0] src_data_i;
  logic [NSRC-1:0]       src_rden_o;
  logic [WIDTH-1:0]      tx_d;
  logic                  tx_src_rdy_n;
  logic                  tx_dst_rdy_n;
  logic [NSRC-1:0]       grant_o;
  logic                  busy_o;

  tx_fifo_arbiter #(.WIDTH(32), .NSRC(4), .SRCW(2), .BURST(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .link_active  (link_active),
    .src_empty_i  (src_empty_i),
    .src_data_i   (src_data_i),
    .src_rden_o   (src_rden_o),
    .tx_d         (tx_d),
    .tx_src_rdy_n (tx_src_rdy_n),
    .tx_dst_rdy_n (tx_dst_rdy_n),
    .grant_o      (grant_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        dst_n;
    logic        e_rdy_n;
    logic [31:0] e_d;
    logic [3:0]  e_rden;
    logic [3:0]  e_grant;
    logic        e_busy;
  } vec_t;

  logic [31:0] fq [NSRC][$];
  logic [31:0] rx [$];
  logic [31:0] exp_q [$];
  int          pops [NSRC];
  int          ticks;
  int          total;
  int          bad;

  logic        l_rdy_n;
  logic [31:0] l_d;
  logic [3:0]  l_rden;
  logic [3:0]  l_grant;
  logic        l_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, ticks);
    end
  endtask

  function automatic logic [31:0] rxw(input int i);
    if (i < rx.size()) return rx[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic update_srcs();
    for (int k = 0; k < NSRC; k++) begin
      src_empty_i[k] = (fq[k].size() == 0);
      src_data_i[k*WIDTH +: WIDTH] = (fq[k].size() == 0) ? 32'h0 : fq[k][0];
    end
  endtask

  // One clock: sample outputs at negedge, then apply the model pops after posedge.
  task automatic tick();
    @(negedge clk);
    l_rdy_n = tx_src_rdy_n;
    l_d     = tx_d;
    l_rden  = src_rden_o;
    l_grant = grant_o;
    l_busy  = busy_o;
    if (!tx_src_rdy_n && !tx_dst_rdy_n) rx.push_back(tx_d);
    @(posedge clk);
    #1;
    for (int k = 0; k < NSRC; k++) begin
      if (l_rden[k]) begin
        if (fq[k].size() > 0) void'(fq[k].pop_front());
        pops[k]++;
      end
    end
    update_srcs();
    ticks++;
  endtask

  task automatic do_reset();
    for (int k = 0; k < NSRC; k++) begin
      fq[k].delete();
      pops[k] = 0;
    end
    update_srcs();
    tx_dst_rdy_n = 1'b0;
    link_active  = 1'b1;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
    rx.delete();
    ticks = 0;
    for (int k = 0; k < NSRC; k++) pops[k] = 0;
  endtask

  task automatic load(input int k, input int n, input logic [31:0] base);
    for (int j = 0; j < n; j++) fq[k].push_back(base + 32'(j));
    update_srcs();
  endtask

  task automatic run_until(input string name, input int n, input int maxt);
    int t;
    t = 0;
    while (rx.size() < n && t < maxt) begin
      tick();
      t++;
    end
    chk(name, 32'(rx.size()), 32'(n));
  endtask

  vec_t tv [9];
  logic [15:0] pat;
  logic        prev_stall;
  logic [31:0] prev_d;
  int          s;

  initial begin
    total = 0;
    bad   = 0;
    ticks = 0;
    rst   = 1'b1;
    link_active  = 1'b1;
    tx_dst_rdy_n = 1'b0;
    src_empty_i  = '1;
    src_data_i   = '0;

    tv[0] = '{1'b0, 1'b1, 32'h0,        4'b0000, 4'b0000, 1'b0};
    tv[1] = '{1'b0, 1'b0, 32'hA500_0001, 4'b0000, 4'b0010, 1'b1};
    tv[2] = '{1'b0, 1'b0, 32'h11,       4'b0010, 4'b0010, 1'b1};
    tv[3] = '{1'b1, 1'b0, 32'h22,       4'b0000, 4'b0010, 1'b1};
    tv[4] = '{1'b0, 1'b0, 32'h22,       4'b0010, 4'b0010, 1'b1};
    tv[5] = '{1'b0, 1'b0, 32'h33,       4'b0010, 4'b0010, 1'b1};
    tv[6] = '{1'b0, 1'b1, 32'h0,        4'b0000, 4'b0010, 1'b1};
    tv[7] = '{1'b0, 1'b0, 32'h5A00_0003, 4'b0000, 4'b0010, 1'b1};
    tv[8] = '{1'b0, 1'b1, 32'h0,        4'b0000, 4'b0000, 1'b0};

    // Single 3-word packet from source 1, cycle by cycle, with one stall.
    do_reset();
    fq[1].push_back(32'h11);
    fq[1].push_back(32'h22);
    fq[1].push_back(32'h33);
    update_srcs();
    for (int i = 0; i < 9; i++) begin
      tx_dst_rdy_n = tv[i].dst_n;
      tick();
      chk($sformatf("v%0d_rdy_n", i), 32'(l_rdy_n), 32'(tv[i].e_rdy_n));
      chk($sformatf("v%0d_tx_d", i),  l_d,           tv[i].e_d);
      chk($sformatf("v%0d_rden", i),  32'(l_rden),   32'(tv[i].e_rden));
      chk($sformatf("v%0d_grant", i), 32'(l_grant),  32'(tv[i].e_grant));
      chk($sformatf("v%0d_busy", i),  32'(l_busy),   32'(tv[i].e_busy));
    end
    chk("t1_pops", 32'(pops[1]), 32'd3);

    // Four full sources, BURST=16: two rounds in order 1,2,3,0.
    do_reset();
    for (int k = 0; k < NSRC; k++) load(k, 20, 32'(k * 256));
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      for (int m = 0; m < 4; m++) begin
        int k;
        int n;
        k = (m + 1) % 4;
        n = (r == 0) ? 16 : 4;
        exp_q.push_back(32'hA500_0000 | 32'(k));
        for (int j = 0; j < n; j++) exp_q.push_back(32'(k * 256 + r * 16 + j));
        exp_q.push_back(32'h5A00_0000 | 32'(n));
      end
    end
    run_until("t2_len", exp_q.size(), 400);
    for (int i = 0; i < exp_q.size(); i++) chk($sformatf("t2_w%0d", i), rxw(i), exp_q[i]);
    chk("t2_ticks", 32'(ticks), 32'd108);
    for (int k = 0; k < NSRC; k++) chk($sformatf("t2_pops%0d", k), 32'(pops[k]), 32'd20);

    // Backpressure on a 10-word packet from source 0.
    do_reset();
    load(0, 10, 32'h0B00);
    pat = 16'hA6C9;
    prev_stall = 1'b0;
    prev_d = '0;
    for (int i = 0; i < 200 && rx.size() < 12; i++) begin
      tx_dst_rdy_n = pat[i % 16];
      tick();
      chk("t3_pop_on_stall", 32'(l_rden & {4{tx_dst_rdy_n}}), 32'h0);
      if (prev_stall) chk("t3_stable", l_d, prev_d);
      prev_stall = !l_rdy_n && tx_dst_rdy_n;
      prev_d = l_d;
    end
    tx_dst_rdy_n = 1'b0;
    chk("t3_len", 32'(rx.size()), 32'd12);
    chk("t3_hdr", rxw(0), 32'hA500_0000);
    for (int j = 0; j < 10; j++) chk($sformatf("t3_w%0d", j), rxw(j + 1), 32'h0B00 + 32'(j));
    chk("t3_trl", rxw(11), 32'h5A00_000A);
    chk("t3_pops", 32'(pops[0]), 32'd10);

    // Source 2 runs dry after 5 words; refill must not win the next grant.
    do_reset();
    load(2, 5, 32'h0200);
    load(0, 2, 32'h0C00);
    run_until("t4_len1", 7, 100);
    chk("t4_hdr", rxw(0), 32'hA500_0002);
    for (int j = 0; j < 5; j++) chk($sformatf("t4_w%0d", j), rxw(j + 1), 32'h0200 + 32'(j));
    chk("t4_trl", rxw(6), 32'h5A00_0005);
    load(2, 11, 32'h0205);
    run_until("t4_len2", 8, 100);
    chk("t4_next_hdr", rxw(7), 32'hA500_0000);

    // Link drop after the 3rd data word of a source-3 packet.
    do_reset();
    load(3, 8, 32'h0300);
    run_until("t5_len1", 4, 100);
    load(0, 1, 32'h0D00);
    link_active = 1'b0;
    tick();
    chk("t5_drop_rden", 32'(l_rden), 32'h0);
    chk("t5_drop_rdy_n", 32'(l_rdy_n), 32'd1);
    link_active = 1'b1;
    tick();
    chk("t5_after_rdy_n", 32'(l_rdy_n), 32'd1);
    chk("t5_after_busy", 32'(l_busy), 32'd0);
    chk("t5_no_trl", 32'(rx.size()), 32'd4);
    chk("t5_pops", 32'(pops[3]), 32'd3);
    run_until("t5_len2", 12, 100);
    chk("t5_hdr2", rxw(4), 32'hA500_0003);
    for (int j = 0; j < 5; j++) chk($sformatf("t5_w%0d", j), rxw(j + 5), 32'h0303 + 32'(j));
    chk("t5_trl2", rxw(10), 32'h5A00_0005);
    chk("t5_hdr3", rxw(11), 32'hA500_0000);

    // Reset in the middle of a source-2 burst, with ptr previously at 1.
    do_reset();
    load(1, 2, 32'h0100);
    run_until("t6_len1", 4, 100);
    load(2, 8, 32'h0600);
    load(1, 1, 32'h01FF);
    run_until("t6_len2", 7, 100);
    chk("t6_hdr", rxw(4), 32'hA500_0002);
    rst = 1'b1;
    tick();
    chk("t6_rst_rden", 32'(l_rden), 32'h0);
    rst = 1'b0;
    tick();
    chk("t6_rdy_n", 32'(l_rdy_n), 32'd1);
    chk("t6_tx_d", l_d, 32'h0);
    chk("t6_rden", 32'(l_rden), 32'h0);
    chk("t6_grant", 32'(l_grant), 32'h0);
    chk("t6_busy", 32'(l_busy), 32'd0);
    chk("t6_pops", 32'(pops[2]), 32'd2);
    s = rx.size();
    run_until("t6_len3", s + 1, 100);
    chk("t6_ptr_reset_hdr", rxw(s), 32'hA500_0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
